r2sdf_stage_sched: RTL
======================

# r2sdf_stage_sched

Sequencer for a radix-2 single-delay-feedback (R2SDF) decimation-in-frequency FFT pipeline of N = 2**LOG2N points. It tracks a per-stage sample index and drives each stage's butterfly/bypass select and the address of that stage's twiddle coefficient ROM. The ROM is a 1-clk registered cos/sin table with 2**AW entries, where entry k = W(pi*k/2**AW). The block also reports when the last stage produces valid output, and the output sample index in bit-reversed order.

## Interface
Parameters:
- LOG2N, 9, log2 of FFT length; legal range 2..12.
- PIPE, 2, register latency per stage beyond its D_s feedback delay, counted in accepted samples (butterfly, ROM and multiplier registers).
- AW, LOG2N-1, twiddle ROM address width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  a sample enters stage 0 this cycle. It is also the clock enable of the whole datapath.
- in_sof  in  1  qualified by in_valid: the current sample is index 0 of a new frame (resync).
- bf_sel  out  LOG2N  bit s = 1: stage s is in butterfly phase; 0: stage s is in bypass/drain phase.
- tw_addr  out  LOG2N*AW  stage s ROM address in bits [s*AW +: AW].
- out_valid  out  1  last stage emits a valid result this cycle.
- out_sof  out  1  out_valid and out_idx == 0.
- out_idx  out  LOG2N  bit-reversed frequency index of the current output.

## Operation
- Per-stage constants:
  - D_s = N >> (s+1).
  - offset_s = sum over j<s of (D_j + PIPE).
  - LAT = offset_LOG2N = N-1 + LOG2N*PIPE.
- Per-stage counter cnt_s (LOG2N bits, wraps mod N) holds the stage-local index of the sample at the stage s input.
  - Reset: cnt_s = (N - offset_s) mod N.
  - On in_valid: cnt_s increments by 1, with wrap.
- bf_sel[s] = cnt_s[LOG2N-1-s]. Combinational from the registered counter.
- tw_addr for stage s is combinational from cnt_s:
  - If bf_sel[s] == 0: tw_addr_s = (cnt_s mod D_s) << s.
  - Otherwise: tw_addr_s = 0 (unity twiddle).
  - The value always fits AW bits.
  - The last stage (D = 1) is always address 0.
- Prime counter pcnt (saturates at LAT) tracks flushing:
  - Reset value 0. Increments on in_valid while pcnt < LAT.
  - primed = (pcnt == LAT).
- out_valid = in_valid & primed & ~(in_valid & in_sof). Combinational.
- Output index counter ocnt:
  - Reset value 0. Increments on out_valid, with wrap.
  - out_idx = ocnt. out_sof = out_valid & (ocnt == 0).
- Resync (in_valid & in_sof):
  - Overrides the normal increment. Pipeline contents are discarded.
  - After the edge: cnt_s = (N - offset_s + 1) mod N, pcnt = 1, ocnt = 0.
  - out_valid is 0 during the resync cycle.
- in_sof with in_valid = 0 is ignored.
- in_valid = 0 (stall): all registers hold, so bf_sel and tw_addr are stable.

## Timing
- Reset values:
  - bf_sel[s] = bit LOG2N-1-s of (N - offset_s) mod N.
  - tw_addr follows from the reset counters.
  - out_valid = 0, out_sof = 0, out_idx = 0.
- A rst asserted mid-frame restores all reset values at the next edge. It has priority over in_valid and in_sof.
- ROM latency: coefficient for cnt_s appears at ROM qout 1 clk after cnt_s is registered. This clk is included in PIPE by the datapath.
- Decode latency: bf_sel, tw_addr, out_* change in the same cycle as the counter update. No extra register stage.
- First out_valid: on the (LAT+1)th accepted sample after reset or resync, which is the LAT+1th accepted sample counting the resync sample.
- Throughput: one sample per clk with in_valid held high. Stalls of any length insert no bubbles into the index sequence.
- Wrap: cnt_s and ocnt roll from N-1 to 0 without a gap. out_sof recurs every N valid outputs.

## Test plan
Unless noted, LOG2N=3 (N=8, AW=2), PIPE=1. Then D = 4,2,1, offsets = 0,5,8, LAT = 10.
- Reset check: rst high 2 clks, then low with in_valid=0 -> bf_sel = 3'b010 (cnt = 0,3,0); tw_addr0=0, tw_addr1=0, tw_addr2=0; out_valid=0, out_idx=0.
- Stage 0 sequence: in_valid high 8 clks -> tw_addr0 = 0,1,2,3,0,0,0,0 and bf_sel[0] = 0,0,0,0,1,1,1,1.
- Stage 1 sequence: same run -> tw_addr1 = 0,0,2,0,0,0,2,0 and bf_sel[1] = 1,0,0,1,1,0,0,1.
- Prime and output: in_valid continuous -> out_valid first high on accepted sample 11 with out_sof=1, out_idx=0. out_idx then counts 1..7,0, with out_sof again 8 valid outputs later.
- Stall: drop in_valid for 3 clks mid-frame -> all outputs frozen. On resume the sequence continues exactly where it stopped, and out_idx has no gaps.
- Resync: in_valid & in_sof while primed -> out_valid=0 that cycle; next cycle cnt = 1,4,1 and pcnt=1; the next out_valid comes 10 accepted samples later with out_idx=0. A second case with rst and in_sof together -> reset wins.

Source files
------------

// File: rtl/r2sdf_stage_sched_if.sv
// Handshake and decode bus between the R2SDF stage sequencer and its datapath.
interface r2sdf_stage_sched_if #(
    parameter int unsigned LOG2N = 9
);
    localparam int unsigned AW = LOG2N - 1;

    logic                   in_valid;
    logic                   in_sof;
    logic [LOG2N-1:0]       bf_sel;
    logic [LOG2N*AW-1:0]    tw_addr;
    logic                   out_valid;
    logic                   out_sof;
    logic [LOG2N-1:0]       out_idx;

    modport master (
        output in_valid,
        output in_sof,
        input  bf_sel,
        input  tw_addr,
        input  out_valid,
        input  out_sof,
        input  out_idx
    );

    modport slave (
        input  in_valid,
        input  in_sof,
        output bf_sel,
        output tw_addr,
        output out_valid,
        output out_sof,
        output out_idx
    );
endinterface

// File: rtl/r2sdf_stage_sched.sv
// Sample-index sequencer for an R2SDF DIF FFT: per-stage butterfly select and
// twiddle ROM address, pipeline prime tracking and bit-reversed output index.
module r2sdf_stage_sched #(
    parameter int unsigned LOG2N = 9,
    parameter int unsigned PIPE  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    r2sdf_stage_sched_if.slave   bus
);
    localparam int unsigned N   = 1 << LOG2N;
    localparam int unsigned AW  = LOG2N - 1;
    localparam int unsigned LAT = N - 1 + LOG2N * PIPE;
    localparam int unsigned PW  = $clog2(LAT + 1);

    logic [LOG2N-1:0]    bf_sel_c;
    logic [LOG2N*AW-1:0] tw_addr_c;
    logic [PW-1:0]       pcnt;
    logic [LOG2N-1:0]    ocnt;
    logic                primed_c;
    logic                resync_c;
    logic                out_valid_c;

    assign resync_c = bus.in_valid & bus.in_sof;

    for (genvar s = 0; s < LOG2N; s++) begin : g_stage
        localparam int unsigned      D    = N >> (s + 1);
        localparam int unsigned      OFFS = (N - (N >> s)) + s * PIPE;
        // Truncation to LOG2N bits gives the mod-N reset phase even when OFFS > N.
        localparam logic [LOG2N-1:0] INIT = LOG2N'(N - OFFS);
        localparam logic [LOG2N-1:0] MASK = LOG2N'(D - 1);

        logic [LOG2N-1:0] cnt;
        logic [LOG2N-1:0] phase_idx_c;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= INIT;
            end else if (bus.in_valid) begin
                cnt <= bus.in_sof ? INIT + LOG2N'(1) : cnt + LOG2N'(1);
            end
        end

        // Drain phase walks the twiddle table with stride 2**s; butterfly phase uses W^0.
        assign phase_idx_c              = (cnt & MASK) << s;
        assign bf_sel_c[s]              = cnt[LOG2N-1-s];
        assign tw_addr_c[s*AW +: AW]    = bf_sel_c[s] ? '0 : AW'(phase_idx_c);
    end

    assign primed_c    = (pcnt == PW'(LAT));
    assign out_valid_c = bus.in_valid & primed_c & ~resync_c;

    // Prime counter saturates once the last stage holds real data.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
            ocnt <= '0;
        end else if (bus.in_valid) begin
            if (bus.in_sof) begin
                pcnt <= PW'(1);
                ocnt <= '0;
            end else begin
                if (!primed_c) pcnt <= pcnt + PW'(1);
                if (out_valid_c) ocnt <= ocnt + LOG2N'(1);
            end
        end
    end

    assign bus.bf_sel    = bf_sel_c;
    assign bus.tw_addr   = tw_addr_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_sof   = out_valid_c & (ocnt == '0);
    assign bus.out_idx   = ocnt;
endmodule
